// File: rtl/delay_line_arbiter.sv
// Arbitrates N_REQ requesters onto one shared fixed-latency delay line and routes
// returning words back by tag. Define DLA_RR_EN for round-robin; default is fixed priority.
module delay_line_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [N_REQ-1:0]        req_i,
  input  logic [N_REQ*DATA_W-1:0] data_i,
  output logic [N_REQ-1:0]        gnt_o,
  input  logic                    flush_i,
  output logic                    pipe_vld_o,
  output logic [DATA_W-1:0]       pipe_data_o,
  input  logic [DATA_W-1:0]       pipe_data_i,
  output logic [N_REQ-1:0]        rsp_vld_o,
  output logic [DATA_W-1:0]       rsp_data_o,
  output logic                    busy_o
);

  localparam int IW = (N_REQ > 2) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]  gnt;
  logic [IW-1:0]     gnt_idx;
  logic              gnt_found;
  logic              xfer;
  logic [DATA_W-1:0] gnt_data;

  logic              pipe_vld_q;
  logic [DATA_W-1:0] pipe_data_q;
  logic [DEPTH:0]    tag_vld_q;
  logic [IW-1:0]     tag_idx_q [DEPTH+1];

`ifdef DLA_RR_EN
  logic [IW-1:0]     ptr_q;
`endif

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
`ifdef DLA_RR_EN
    // Two ascending passes: indices above the pointer first, then the wrapped part.
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!gnt_found && req_i[k] && (k > 32'(ptr_q))) begin
        gnt_found = 1'b1;
        gnt_idx   = IW'(k);
      end
    end
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!gnt_found && req_i[k] && (k <= 32'(ptr_q))) begin
        gnt_found = 1'b1;
        gnt_idx   = IW'(k);
      end
    end
`else
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!gnt_found && req_i[k]) begin
        gnt_found = 1'b1;
        gnt_idx   = IW'(k);
      end
    end
`endif
  end

  always_comb begin
    gnt      = '0;
    gnt_data = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      gnt[k] = gnt_found && (gnt_idx == IW'(k)) && !rst_i && !flush_i;
      if (gnt_idx == IW'(k)) begin
        gnt_data = data_i[k*DATA_W +: DATA_W];
      end
    end
  end

  assign xfer = |gnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pipe_vld_q  <= 1'b0;
      pipe_data_q <= '0;
      tag_vld_q   <= '0;
`ifdef DLA_RR_EN
      ptr_q       <= IW'(N_REQ - 1);
`endif
    end else begin
      pipe_vld_q <= xfer;
      if (xfer) begin
        pipe_data_q <= gnt_data;
      end
      tag_vld_q <= flush_i ? '0 : {tag_vld_q[DEPTH-1:0], xfer};
`ifdef DLA_RR_EN
      if (xfer) begin
        ptr_q <= gnt_idx;
      end
`endif
    end
  end

  // Tag indices only matter where the matching valid bit is set, so they need no reset.
  always_ff @(posedge clk_i) begin
    tag_idx_q[0] <= gnt_idx;
    for (int unsigned i = 1; i <= DEPTH; i++) begin
      tag_idx_q[i] <= tag_idx_q[i-1];
    end
  end

  always_comb begin
    rsp_vld_o = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      rsp_vld_o[k] = tag_vld_q[DEPTH] && (tag_idx_q[DEPTH] == IW'(k));
    end
  end

  assign gnt_o       = gnt;
  assign pipe_vld_o  = pipe_vld_q;
  assign pipe_data_o = pipe_data_q;
  assign rsp_data_o  = pipe_data_i;
  assign busy_o      = pipe_vld_q | (|tag_vld_q);

endmodule

// File: tb/tb_delay_line_arbiter.sv
// Bench for delay_line_arbiter: directed steps plus constrained-random traffic against a
// transaction-history model; the external delay line is modelled here as a DEPTH-stage shift.
module tb_delay_line_arbiter;
  localparam int N    = 4;
  localparam int W    = 8;
  localparam int D    = 2;
  localparam int MAXC = 4096;

  logic           clk = 1'b0;
  logic           rst;
  logic           flush;
  logic [N-1:0]   req;
  logic [N*W-1:0] data;
  logic [N-1:0]   gnt;
  logic           pvld;
  logic [W-1:0]   pdo;
  logic [W-1:0]   pdi;
  logic [N-1:0]   rsp_vld;
  logic [W-1:0]   rdata;
  logic           busy;

  always #5 clk = ~clk;

  delay_line_arbiter #(.N_REQ(N), .DATA_W(W), .DEPTH(D)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .data_i(data), .gnt_o(gnt),
    .flush_i(flush), .pipe_vld_o(pvld), .pipe_data_o(pdo), .pipe_data_i(pdi),
    .rsp_vld_o(rsp_vld), .rsp_data_o(rdata), .busy_o(busy)
  );

  logic [W-1:0] line [D];
  always @(posedge clk) begin
    line[0] <= pdo;
    for (int i = 1; i < D; i++) line[i] <= line[i-1];
  end
  assign pdi = line[D-1];

  // Model: per-cycle transfer history; a flush or reset cancels every transfer still in flight.
  int           cyc = 0;
  int           m_ptr = N - 1;
  bit           armed = 1'b0;
  bit           xfer_h [MAXC];
  bit           live_h [MAXC];
  int           idx_h  [MAXC];
  logic [W-1:0] data_h [MAXC];
  logic [W-1:0] m_last = '0;
  int           checks = 0;
  int           errors = 0;

  function automatic int pick(input logic [N-1:0] r);
`ifdef DLA_RR_EN
    for (int i = 1; i <= N; i++) begin
      if (r[(m_ptr + i) % N]) return (m_ptr + i) % N;
    end
`else
    for (int k = 0; k < N; k++) begin
      if (r[k]) return k;
    end
`endif
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic cycle(input logic [N-1:0] r, input logic [N*W-1:0] d,
                       input logic f, input logic rs, output int g);
    logic [N-1:0] eg;
    logic [N-1:0] ersp;
    bit           ebusy;
    int           src;
    req = r; data = d; flush = f; rst = rs;
    #1;
    g  = (rs || f) ? -1 : pick(r);
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    chk("gnt", 32'(gnt), 32'(eg));
    if (armed) begin
      chk("pipe_vld", 32'(pvld), 32'(cyc >= 1 && xfer_h[cyc-1]));
      chk("pipe_data", 32'(pdo), 32'(m_last));
      src  = cyc - 1 - D;
      ersp = '0;
      if (src >= 0 && live_h[src]) ersp[idx_h[src]] = 1'b1;
      chk("rsp_vld", 32'(rsp_vld), 32'(ersp));
      if (ersp != '0) chk("rsp_data", 32'(rdata), 32'(data_h[src]));
      ebusy = (cyc >= 1) && xfer_h[cyc-1];
      for (int t = cyc - 1 - D; t <= cyc - 1; t++) begin
        if (t >= 0 && live_h[t]) ebusy = 1'b1;
      end
      chk("busy", 32'(busy), 32'(ebusy));
    end
    @(posedge clk);
    if (rs || f) begin
      for (int t = cyc - D; t < cyc; t++) begin
        if (t >= 0) live_h[t] = 1'b0;
      end
      if (rs) begin
        m_ptr  = N - 1;
        m_last = '0;
        armed  = 1'b1;
      end
    end else if (g >= 0) begin
      xfer_h[cyc] = 1'b1;
      live_h[cyc] = 1'b1;
      idx_h[cyc]  = g;
      data_h[cyc] = d[g*W +: W];
      m_last      = d[g*W +: W];
      m_ptr       = g;
    end
    cyc++;
    @(negedge clk);
  endtask

  logic [N-1:0]   preq;
  logic [N*W-1:0] pdata;
  logic [N*W-1:0] inc;
  int             g;

  initial begin
    req = '0; data = '0; flush = 1'b0; rst = 1'b1;
    for (int k = 0; k < N; k++) inc[k*W +: W] = W'(8'h10 + k);
    @(negedge clk);
    cycle('0, '0, 1'b0, 1'b1, g);
    cycle('0, '0, 1'b0, 1'b1, g);
    for (int i = 0; i < 5; i++) cycle('0, '0, 1'b0, 1'b0, g);

    cycle(4'b0001, {24'h0, 8'hA5}, 1'b0, 1'b0, g);
    for (int i = 0; i < 4; i++) cycle('0, '0, 1'b0, 1'b0, g);

    cycle('0, '0, 1'b0, 1'b1, g);
    for (int i = 0; i < 8; i++) cycle(4'b1111, inc, 1'b0, 1'b0, g);
    for (int i = 0; i < 4; i++) cycle('0, '0, 1'b0, 1'b0, g);

    cycle(4'b0001, {24'h0, 8'h31}, 1'b0, 1'b0, g);
    cycle(4'b0010, {16'h0, 8'h32, 8'h0}, 1'b0, 1'b0, g);
    cycle('0, '0, 1'b1, 1'b0, g);
    cycle(4'b0100, {8'h0, 8'h33, 16'h0}, 1'b0, 1'b0, g);
    for (int i = 0; i < 5; i++) cycle('0, '0, 1'b0, 1'b0, g);

    cycle(4'b1000, {8'h44, 24'h0}, 1'b0, 1'b0, g);
    cycle('0, '0, 1'b0, 1'b1, g);
    cycle(4'b1111, inc, 1'b0, 1'b0, g);
    for (int i = 0; i < 5; i++) cycle('0, '0, 1'b0, 1'b0, g);

    preq = '0; pdata = '0;
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < N; k++) begin
        if (!preq[k] && $urandom_range(0, 99) < 40) begin
          preq[k]           = 1'b1;
          pdata[k*W +: W]   = W'($urandom);
        end
      end
      cycle(preq, pdata, $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 2, g);
      if (g >= 0 && !rst && !flush) preq[g] = 1'b0;
    end
    for (int i = 0; i < 5; i++) cycle('0, '0, 1'b0, 1'b0, g);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/delay_line_arbiter.md
Name: delay_line_arbiter

Overview:
- Shares one external fixed-latency delay line, a DEPTH-stage register shift pipeline, between N_REQ requesters.
- Round-robin arbitration picks one requester per cycle and drives the shared pipeline input.
- An internal tag shift register runs in parallel with the external pipeline, so each word leaving the pipeline returns to the requester that sent it.
- Sits between the requester blocks and the shared shift/delay datapath.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_W, 8, data width per requester and of the pipeline
DEPTH, 2, latency in clk_i cycles of the external delay line from pipe_data_o to pipe_data_i (>=1)

Ports:
clk_i  input  1  clock, all logic on rising edge
rst_i  input  1  synchronous reset, active-high
req_i  input  N_REQ  per-requester valid
data_i  input  N_REQ*DATA_W  per-requester data, requester k at bits [k*DATA_W +: DATA_W]
gnt_o  output  N_REQ  one-hot grant (ready), combinational from req_i, pointer and flush_i
flush_i  input  1  discard all in-flight tags
pipe_vld_o  output  1  registered valid into the shared delay line
pipe_data_o  output  DATA_W  registered data into the shared delay line
pipe_data_i  input  DATA_W  data returning from the delay line
rsp_vld_o  output  N_REQ  one-hot: returning word belongs to requester k
rsp_data_o  output  DATA_W  equals pipe_data_i (pass-through)
busy_o  output  1  OR of pipe_vld_o and all tag valids

Behaviour:
- Reset (rst_i=1 at posedge):
  - pipe_vld_o=0, pipe_data_o=0.
  - All tag stages invalid, so rsp_vld_o=0 and busy_o=0.
  - RR pointer = N_REQ-1, so requester 0 has highest priority first.
  - gnt_o=0 while rst_i=1.
  - Reset mid-operation drops all in-flight words; no response is ever issued for them.
- Arbitration:
  - Search order starts at pointer+1 and wraps modulo N_REQ.
  - The first k with req_i[k]=1 gets gnt_o[k]=1; at most one grant bit is set.
  - gnt_o=0 when no request is active, or when flush_i=1.
- Transfer: happens at cycle t when req_i[k] & gnt_o[k].
  - At t+1: pipe_vld_o=1, pipe_data_o=data_i[k], tag stage 0 = {valid=1, idx=k}.
  - Pointer <= k at t+1. Pointer is unchanged on cycles with no transfer.
  - A requester must hold req_i and data_i stable until granted; the block does not check this.
- No transfer: at t+1, pipe_vld_o=0. pipe_data_o holds its last value.
- Tag pipeline:
  - DEPTH stages; stage i+1 <= stage i every cycle, with no stall.
  - rsp_vld_o[idx] = valid of stage DEPTH.
  - End-to-end latency from transfer to response is DEPTH+1 cycles: response at t+1+DEPTH.
  - Throughput is one word per cycle. Back-to-back grants to different or the same requester are allowed.
- flush_i=1 at posedge:
  - All tag valids clear.
  - pipe_vld_o <= 0 and no transfer happens that cycle.
  - The pointer is unchanged.
  - Data still inside the external line is ignored; no rsp_vld_o is raised for it.
- Width: tag idx width = clog2(N_REQ), minimum 1. rsp_vld_o is a decode of idx gated by valid.

Optional Feature:
- Macro: DLA_RR_EN.
- Defined: round-robin arbitration with pointer, as described above.
- Not defined: fixed priority, lowest index wins. The pointer register is not instantiated. Tag and response behaviour are identical.

Test Plan:
- Reset then req_i=4'b0000 for 5 cycles -> gnt_o=0, pipe_vld_o=0, rsp_vld_o=0, busy_o=0.
- DEPTH=2; req_i=4'b0001, data_i[0]=8'hA5 for one cycle at t -> gnt_o=4'b0001 at t; pipe_vld_o=1 and pipe_data_o=8'hA5 at t+1; rsp_vld_o=4'b0001 at t+3 with rsp_data_o=8'hA5 (bench models the 2-stage line).
- req_i=4'b1111 held, data k = 8'h10+k (DLA_RR_EN) -> grants 0,1,2,3,0,... on consecutive cycles; responses 8'h10,8'h11,8'h12,8'h13 at rsp_vld_o 0001,0010,0100,1000, each 3 cycles after its grant.
- Same stimulus without DLA_RR_EN -> gnt_o=4'b0001 every cycle; requesters 1..3 starve.
- Grants at t and t+1, flush_i=1 at t+2 -> no rsp_vld_o at t+3 or t+4; busy_o=0 at t+3; new grant at t+3 responds normally at t+6.
- rst_i=1 at t+1 after a grant at t -> no response at t+3; pointer back to N_REQ-1, so requester 0 is granted first when req_i=4'b1111.
